icu_fetch_queue: RTL
====================

// Module: icu_fetch_queue
// PURPOSE
//  Instruction fetch stage directly upstream of the ICU dispatcher. On a start pulse it streams a program
//  (start address, instruction count) out of the synchronous instruction memory into a small prefetch FIFO.
//  It presents buffered instructions to the dispatcher with a valid/ready handshake, decoupling memory
//  issue from dispatch stalls.
// PARAMETERS
//  INSTR_WIDTH           32  instruction word width
//  INSTR_MEM_ADDR_WIDTH  10  instruction memory address width (AW)
//  FIFO_DEPTH             4  prefetch entries; power of two, >=2
// PORTS
//  clk           in   1        clock, all logic on posedge
//  rst_n         in   1        asynchronous, active-low reset
//  start         in   1        1-cycle pulse; launches a program when idle
//  abort         in   1        synchronous flush, returns to IDLE
//  start_addr    in   AW       first instruction address
//  instr_count   in   AW+1     instructions to fetch (0..2^AW)
//  imem_req      out  1        memory read strobe
//  imem_addr     out  AW       memory read address
//  imem_rdata    in   32       read data, valid exactly 1 cycle after imem_req
//  instr_valid   out  1        FIFO head valid toward dispatcher
//  instr_out     out  32       FIFO head word
//  instr_ready   in   1        dispatcher accepts head this cycle
//  busy          out  1        state != IDLE
//  done          out  1        1-cycle pulse after last instruction accepted
//  fifo_level    out  log2(FIFO_DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - State IDLE; imem_req=0, imem_addr=0, instr_valid=0, busy=0, done=0, fifo_level=0.
//   - In-flight tag cleared.
//  States:
//   - IDLE:  start & instr_count!=0 -> FETCH; latch addr=start_addr, issue_left=pop_left=instr_count.
//            start & instr_count==0 -> done pulses next cycle; state stays IDLE.
//   - FETCH: all issued (issue_left==0) -> DRAIN.
//   - DRAIN: pop_left==0 -> IDLE, done=1 for that one cycle.
//   - start while busy is ignored.
//  Issue rule:
//   - imem_req=1 in FETCH when issue_left!=0 and fifo_level + inflight < FIFO_DEPTH.
//   - inflight is the 1-bit "req issued last cycle" tag.
//   - Each req: imem_addr increments mod 2^AW (wraps 2^AW-1 -> 0), issue_left decrements.
//  Capture:
//   - The cycle after a req, imem_rdata is pushed into the FIFO.
//   - The credit rule guarantees no push is ever dropped at full.
//  Output:
//   - instr_valid = FIFO not empty; instr_out = head, driven from registers, no combinational path from imem.
//   - Pop on instr_valid & instr_ready; pop_left decrements.
//   - Simultaneous push and pop: level unchanged, both take effect.
//   - instr_ready while empty has no effect.
//  Latency:
//   - start -> first imem_req: 1 cycle.
//   - req -> instr_valid: 2 cycles (1 memory + 1 FIFO write).
//   - Steady state: 1 instr/cycle with instr_ready held high.
//  abort (priority over start, any state):
//   - Next cycle: IDLE, FIFO emptied, inflight data discarded, no done pulse.
//   - start in the same cycle as abort is ignored.
//  Counters:
//   - issue_left and pop_left are AW+1 bits; no underflow (never decremented at 0).
// TESTING
//  - Reset: rst_n low mid-FETCH with 3 entries -> outputs zero immediately (no clk edge); busy=0, level=0.
//  - Basic: start_addr=0x010, count=5, ready=1 -> imem_addr 0x010..0x014 in 5 consecutive cycles,
//    words popped in order, done 1 cycle after 5th accept.
//  - Backpressure: DEPTH=4, count=8, ready=0 -> exactly 4 reqs issued, level=4, no further req;
//    raise ready -> remaining 4 fetched, order intact.
//  - Wrap: start_addr=0x3FE, count=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
//  - Zero/ignored start: count=0 -> done pulse, no imem_req;
//    second start during FETCH -> no effect on address sequence.
//  - Abort: abort with 2 entries queued and 1 in flight -> next cycle instr_valid=0, level=0, no done;
//    new start then fetches cleanly.

Source files
------------

// File: rtl/icu_fetch_queue.sv
// Instruction fetch stage: streams a program from synchronous imem into a small
// prefetch FIFO and hands words to the dispatcher over a valid/ready handshake.
module icu_fetch_queue #(
  parameter int INSTR_WIDTH          = 32,
  parameter int INSTR_MEM_ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [INSTR_MEM_ADDR_WIDTH-1:0]      start_addr,
  input  logic [INSTR_MEM_ADDR_WIDTH:0]        instr_count,
  output logic                                 imem_req,
  output logic [INSTR_MEM_ADDR_WIDTH-1:0]      imem_addr,
  input  logic [INSTR_WIDTH-1:0]               imem_rdata,
  output logic                                 instr_valid,
  output logic [INSTR_WIDTH-1:0]               instr_out,
  input  logic                                 instr_ready,
  output logic                                 busy,
  output logic                                 done,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_level
);

  // state | meaning
  // IDLE  | waiting for start
  // FETCH | issuing memory reads while credit and issue_left allow
  // DRAIN | all reads issued, waiting for the dispatcher to take the rest
  localparam int AW = INSTR_MEM_ADDR_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW:0] DEPTH_C = (LW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t          state;
  logic [AW-1:0]   addr;
  logic [AW:0]     issue_left;
  logic [AW:0]     pop_left;
  logic            inflight;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LW:0]     occupancy;
  logic            push;
  logic            pop;

  logic [INSTR_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  // Credit counts the word still in flight so a push can never land on a full FIFO.
  assign occupancy   = {1'b0, fifo_level} + {{LW{1'b0}}, inflight};
  assign imem_req    = (state == FETCH) && (issue_left != '0) && (occupancy < DEPTH_C);
  assign imem_addr   = addr;
  assign push        = inflight;
  assign pop         = instr_valid && instr_ready;
  assign instr_valid = (fifo_level != '0);
  assign instr_out   = fifo_mem[rd_ptr];
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push && !abort) fifo_mem[wr_ptr] <= imem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      issue_left <= '0;
      pop_left   <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      done       <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      issue_left <= '0;
      pop_left   <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      done       <= 1'b0;
    end else begin
      inflight <= imem_req;
      done     <= 1'b0;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (pop_left != '0) pop_left <= pop_left - 1'b1;
        if (pop_left == CNT_ONE) done <= 1'b1;
      end

      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;

      if (imem_req) begin
        addr       <= addr + 1'b1;
        issue_left <= issue_left - 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            if (instr_count != '0) begin
              state      <= FETCH;
              addr       <= start_addr;
              issue_left <= instr_count;
              pop_left   <= instr_count;
            end else begin
              done <= 1'b1;
            end
          end
        end
        FETCH: if (issue_left == '0) state <= DRAIN;
        DRAIN: if (pop_left == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
